// File: rtl/am_label_vote_filter.sv
// Temporal majority-vote smoothing for the arousal/valence labels produced
// by the late-fusion associative memory. Each dimension keeps its own
// history of accepted (distance <= DIST_THRESH) labels. The filter emits
// the majority label over that history with a valid/ready handshake.

// One vote lane: capture register, label history, fill/vote counters, label.
module am_vote_lane #(
  parameter int LABEL_WIDTH    = 1,
  parameter int DISTANCE_WIDTH = 11,
  parameter int WINDOW         = 5,
  parameter int DIST_THRESH    = 1000,
  parameter int COUNT_WIDTH    = $clog2(WINDOW + 1)
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RBI,
  input  logic                      Capture_S,
  input  logic                      Update_S,
  input  logic                      Flush_S,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_D,
  input  logic [DISTANCE_WIDTH-1:0] DistIn_D,
  output logic [LABEL_WIDTH-1:0]    LabelOut_D,
  output logic [COUNT_WIDTH-1:0]    VoteCount_D,
  output logic [COUNT_WIDTH-1:0]    Fill_D
);

  logic [LABEL_WIDTH-1:0]                labelCap;
  logic [DISTANCE_WIDTH-1:0]             distCap;
  logic [WINDOW-1:0][LABEL_WIDTH-1:0]    hist, histBase, histNext;
  logic [COUNT_WIDTH-1:0]                fill, fillBase, fillNext, ones;
  logic [COUNT_WIDTH:0]                  twiceOnes, fillExt;
  logic [LABEL_WIDTH-1:0]                labelNext;
  logic                                  accept;

  // Post-update history/counters; a same-cycle flush wipes before the push.
  // Slots beyond fill are always zero, so popcount of the full window is
  // the number of 1-votes.
  always_comb begin
    histBase = Flush_S ? '0 : hist;
    fillBase = Flush_S ? '0 : fill;
    accept   = (32'(distCap) <= 32'(DIST_THRESH));
    histNext = histBase;
    fillNext = fillBase;
    if (accept) begin
      for (int i = WINDOW - 1; i >= 1; i--) histNext[i] = histBase[i-1];
      histNext[0] = labelCap;
      if (fillBase < COUNT_WIDTH'(WINDOW)) fillNext = fillBase + COUNT_WIDTH'(1);
    end
    ones = '0;
    for (int i = 0; i < WINDOW; i++)
      if (histNext[i] != '0) ones = ones + COUNT_WIDTH'(1);
    twiceOnes = {ones, 1'b0};
    fillExt   = {1'b0, fillNext};
    labelNext = LabelOut_D;
    if (twiceOnes > fillExt)      labelNext = LABEL_WIDTH'(1);
    else if (twiceOnes < fillExt) labelNext = '0;
  end

  // Capture on handshake, commit on UPDATE, standalone flush otherwise.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      labelCap    <= '0;
      distCap     <= '0;
      hist        <= '0;
      fill        <= '0;
      VoteCount_D <= '0;
      LabelOut_D  <= '0;
    end else begin
      if (Capture_S) begin
        labelCap <= LabelIn_D;
        distCap  <= DistIn_D;
      end
      if (Update_S) begin
        hist        <= histNext;
        fill        <= fillNext;
        VoteCount_D <= ones;
        LabelOut_D  <= labelNext;
      end else if (Flush_S) begin
        hist <= '0;
        fill <= '0;
      end
    end
  end

  assign Fill_D = fill;

endmodule

module am_label_vote_filter #(
  parameter int LABEL_WIDTH    = 1,
  parameter int DISTANCE_WIDTH = 11,
  parameter int WINDOW         = 5,
  parameter int DIST_THRESH    = 1000,
  parameter int COUNT_WIDTH    = $clog2(WINDOW + 1)
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RBI,
  input  logic                      ValidIn_SI,
  output logic                      ReadyOut_SO,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_A_DI,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_V_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_V_DI,
  input  logic                      Flush_SI,
  input  logic                      ReadyIn_SI,
  output logic                      ValidOut_SO,
  output logic [LABEL_WIDTH-1:0]    LabelOut_A_DO,
  output logic [LABEL_WIDTH-1:0]    LabelOut_V_DO,
  output logic [COUNT_WIDTH-1:0]    VoteCount_A_DO,
  output logic [COUNT_WIDTH-1:0]    VoteCount_V_DO,
  output logic [COUNT_WIDTH-1:0]    Fill_A_DO,
  output logic [COUNT_WIDTH-1:0]    Fill_V_DO
);

  localparam int NUM_LANES = 2;  // lane 0 = arousal, lane 1 = valence

  typedef enum logic [1:0] {IDLE, UPDATE, OUTPUT_STABLE} state_e;
  state_e stateQ, stateD;

  logic [NUM_LANES-1:0][LABEL_WIDTH-1:0]    labelIn, labelOut;
  logic [NUM_LANES-1:0][DISTANCE_WIDTH-1:0] distIn;
  logic [NUM_LANES-1:0][COUNT_WIDTH-1:0]    voteCount, fillCount;
  logic                                     capture, update;

  assign labelIn = {LabelIn_V_DI, LabelIn_A_DI};
  assign distIn  = {DistanceIn_V_DI, DistanceIn_A_DI};

  // State register.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) stateQ <= IDLE;
    else            stateQ <= stateD;
  end

  // Next state and handshake outputs.
  always_comb begin
    stateD      = stateQ;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    capture     = 1'b0;
    update      = 1'b0;
    case (stateQ)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          capture = 1'b1;
          stateD  = UPDATE;
        end
      end
      UPDATE: begin
        update = 1'b1;
        stateD = OUTPUT_STABLE;
      end
      OUTPUT_STABLE: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    am_vote_lane #(
      .LABEL_WIDTH   (LABEL_WIDTH),
      .DISTANCE_WIDTH(DISTANCE_WIDTH),
      .WINDOW        (WINDOW),
      .DIST_THRESH   (DIST_THRESH),
      .COUNT_WIDTH   (COUNT_WIDTH)
    ) uLane (
      .Clk_CI     (Clk_CI),
      .Reset_RBI  (Reset_RBI),
      .Capture_S  (capture),
      .Update_S   (update),
      .Flush_S    (Flush_SI),
      .LabelIn_D  (labelIn[g]),
      .DistIn_D   (distIn[g]),
      .LabelOut_D (labelOut[g]),
      .VoteCount_D(voteCount[g]),
      .Fill_D     (fillCount[g])
    );
  end

  assign LabelOut_A_DO  = labelOut[0];
  assign LabelOut_V_DO  = labelOut[1];
  assign VoteCount_A_DO = voteCount[0];
  assign VoteCount_V_DO = voteCount[1];
  assign Fill_A_DO      = fillCount[0];
  assign Fill_V_DO      = fillCount[1];

endmodule

// File: tb/tb_am_label_vote_filter.sv
// Self-checking bench for am_label_vote_filter: directed scenarios plus a
// randomized run, all checked against a queue-based vote model.
module tb_am_label_vote_filter;
  localparam int LW = 1, DW = 11, WIN = 5, CW = 3, TH = 1000;

  logic Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  logic Reset_RBI = 1'b0, ValidIn_SI = 1'b0, Flush_SI = 1'b0, ReadyIn_SI = 1'b0;
  logic ReadyOut_SO, ValidOut_SO;
  logic [LW-1:0] LabelIn_A_DI = '0, LabelIn_V_DI = '0, LabelOut_A_DO, LabelOut_V_DO;
  logic [DW-1:0] DistanceIn_A_DI = '0, DistanceIn_V_DI = '0;
  logic [CW-1:0] VoteCount_A_DO, VoteCount_V_DO, Fill_A_DO, Fill_V_DO;

  am_label_vote_filter #(.LABEL_WIDTH(LW), .DISTANCE_WIDTH(DW), .WINDOW(WIN), .DIST_THRESH(TH)) dut (
    .Clk_CI(Clk_CI), .Reset_RBI(Reset_RBI), .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
    .LabelIn_A_DI(LabelIn_A_DI), .LabelIn_V_DI(LabelIn_V_DI),
    .DistanceIn_A_DI(DistanceIn_A_DI), .DistanceIn_V_DI(DistanceIn_V_DI),
    .Flush_SI(Flush_SI), .ReadyIn_SI(ReadyIn_SI), .ValidOut_SO(ValidOut_SO),
    .LabelOut_A_DO(LabelOut_A_DO), .LabelOut_V_DO(LabelOut_V_DO),
    .VoteCount_A_DO(VoteCount_A_DO), .VoteCount_V_DO(VoteCount_V_DO),
    .Fill_A_DO(Fill_A_DO), .Fill_V_DO(Fill_V_DO));

  int checks = 0, errors = 0;

  // Reference model: accepted labels per dimension, newest at the back.
  bit qa[$], qv[$];
  logic mla = 1'b0, mlv = 1'b0;
  int ea_cnt, ev_cnt, ea_fill, ev_fill;

  function automatic logic vote(input int n1, input int fl, input logic prev);
    if (2 * n1 > fl) return 1'b1;
    if (2 * n1 < fl) return 1'b0;
    return prev;
  endfunction

  task automatic model_reset();
    qa.delete(); qv.delete(); mla = 1'b0; mlv = 1'b0;
  endtask

  task automatic model_step(input logic la, input int da, input logic lv, input int dv, input bit fl);
    if (fl) begin qa.delete(); qv.delete(); end
    if (da <= TH) begin qa.push_back(la); if (qa.size() > WIN) void'(qa.pop_front()); end
    if (dv <= TH) begin qv.push_back(lv); if (qv.size() > WIN) void'(qv.pop_front()); end
    ea_cnt = 0; foreach (qa[i]) ea_cnt += int'(qa[i]);
    ev_cnt = 0; foreach (qv[i]) ev_cnt += int'(qv[i]);
    ea_fill = qa.size(); ev_fill = qv.size();
    mla = vote(ea_cnt, ea_fill, mla);
    mlv = vote(ev_cnt, ev_fill, mlv);
  endtask

  // One transaction: handshake in, optional flush in UPDATE, wait for the
  // result and compare it with the model. Leaves the DUT in OUTPUT_STABLE.
  task automatic send(input logic la, input int da, input logic lv, input int dv, input bit fl);
    int n = 0;
    while (ReadyOut_SO !== 1'b1 && n < 8) begin @(negedge Clk_CI); n++; end
    checks++;
    if (ReadyOut_SO !== 1'b1) begin errors++; $display("FAIL ready_wait: ReadyOut=%b required 1", ReadyOut_SO); end
    ValidIn_SI = 1'b1; LabelIn_A_DI = la; LabelIn_V_DI = lv;
    DistanceIn_A_DI = da[DW-1:0]; DistanceIn_V_DI = dv[DW-1:0];
    @(posedge Clk_CI); @(negedge Clk_CI);
    ValidIn_SI = 1'b0;
    checks++;
    if (ReadyOut_SO !== 1'b0) begin errors++; $display("FAIL ready_after_capture: ReadyOut=%b required 0", ReadyOut_SO); end
    Flush_SI = fl;
    @(posedge Clk_CI); @(negedge Clk_CI);
    Flush_SI = 1'b0;
    n = 0;
    while (ValidOut_SO !== 1'b1 && n < 8) begin @(negedge Clk_CI); n++; end
    checks++;
    if (ValidOut_SO !== 1'b1) begin errors++; $display("FAIL valid_wait: ValidOut=%b required 1", ValidOut_SO); end
    model_step(la, da, lv, dv, fl);
    checks++;
    if (LabelOut_A_DO !== mla || LabelOut_V_DO !== mlv ||
        VoteCount_A_DO !== CW'(ea_cnt) || VoteCount_V_DO !== CW'(ev_cnt) ||
        Fill_A_DO !== CW'(ea_fill) || Fill_V_DO !== CW'(ev_fill)) begin
      errors++;
      $display("FAIL result: got labA=%b labV=%b cntA=%0d cntV=%0d fillA=%0d fillV=%0d required %b %b %0d %0d %0d %0d",
               LabelOut_A_DO, LabelOut_V_DO, VoteCount_A_DO, VoteCount_V_DO, Fill_A_DO, Fill_V_DO,
               mla, mlv, ea_cnt, ev_cnt, ea_fill, ev_fill);
    end
  endtask

  task automatic release_out();
    ReadyIn_SI = 1'b1;
    @(posedge Clk_CI); @(negedge Clk_CI);
    ReadyIn_SI = 1'b0;
  endtask

  task automatic apply_reset();
    Reset_RBI = 1'b0;
    repeat (3) @(negedge Clk_CI);
    Reset_RBI = 1'b1;
    model_reset();
    @(posedge Clk_CI); @(negedge Clk_CI);
    checks++;
    if (ValidOut_SO !== 1'b0 || ReadyOut_SO !== 1'b1 || LabelOut_A_DO !== '0 || LabelOut_V_DO !== '0 ||
        VoteCount_A_DO !== '0 || VoteCount_V_DO !== '0 || Fill_A_DO !== '0 || Fill_V_DO !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b labA=%b labV=%b cntA=%0d cntV=%0d fillA=%0d fillV=%0d required 0 1 0 0 0 0 0 0",
               ValidOut_SO, ReadyOut_SO, LabelOut_A_DO, LabelOut_V_DO, VoteCount_A_DO, VoteCount_V_DO, Fill_A_DO, Fill_V_DO);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk_CI);
    apply_reset();
    send(1'b1, 10, 1'b1, 10, 1'b0);
    apply_reset();  // asserted while in OUTPUT_STABLE
  endtask

  task automatic test_majority();
    logic la_seq[7]  = '{1, 1, 0, 1, 0, 0, 0};
    logic exp_lab[7] = '{1, 1, 1, 1, 1, 0, 0};
    int   exp_cnt[7] = '{1, 2, 2, 3, 3, 2, 1};
    int   exp_fil[7] = '{1, 2, 3, 4, 5, 5, 5};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      send(la_seq[i], 100, 1'($urandom_range(0, 1)), 100, 1'b0);
      checks++;
      if (LabelOut_A_DO !== exp_lab[i] || VoteCount_A_DO !== CW'(exp_cnt[i]) || Fill_A_DO !== CW'(exp_fil[i])) begin
        errors++;
        $display("FAIL majority[%0d]: got lab=%b cnt=%0d fill=%0d required %b %0d %0d",
                 i, LabelOut_A_DO, VoteCount_A_DO, Fill_A_DO, exp_lab[i], exp_cnt[i], exp_fil[i]);
      end
      release_out();
    end
  endtask

  task automatic test_tie_hold();
    logic la_seq[3]  = '{1, 0, 0};
    logic exp_lab[3] = '{1, 1, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(la_seq[i], 50, 1'b0, 50, 1'b0);
      checks++;
      if (LabelOut_A_DO !== exp_lab[i]) begin
        errors++; $display("FAIL tie_hold[%0d]: got %b required %b", i, LabelOut_A_DO, exp_lab[i]);
      end
      release_out();
    end
  endtask

  task automatic test_threshold();
    apply_reset();
    for (int i = 0; i < 5; i++) begin send(1'b0, 100, 1'b0, 100, 1'b0); release_out(); end
    send(1'b1, 1001, 1'b1, 1000, 1'b0);
    checks++;
    if (LabelOut_A_DO !== 1'b0 || VoteCount_A_DO !== 3'd0 || Fill_A_DO !== 3'd5 ||
        VoteCount_V_DO !== 3'd1 || Fill_V_DO !== 3'd5) begin
      errors++;
      $display("FAIL threshold: got labA=%b cntA=%0d fillA=%0d cntV=%0d fillV=%0d required 0 0 5 1 5",
               LabelOut_A_DO, VoteCount_A_DO, Fill_A_DO, VoteCount_V_DO, Fill_V_DO);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] la0, lv0;
    logic [CW-1:0] ca0, cv0, fa0, fv0;
    send(1'b1, 20, 1'b1, 20, 1'b0);
    la0 = LabelOut_A_DO; lv0 = LabelOut_V_DO; ca0 = VoteCount_A_DO;
    cv0 = VoteCount_V_DO; fa0 = Fill_A_DO; fv0 = Fill_V_DO;
    ValidIn_SI = 1'b1; LabelIn_A_DI = 1'b0; LabelIn_V_DI = 1'b0;
    DistanceIn_A_DI = 11'd5; DistanceIn_V_DI = 11'd5;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk_CI); @(negedge Clk_CI);
      checks++;
      if (ValidOut_SO !== 1'b1 || ReadyOut_SO !== 1'b0 || LabelOut_A_DO !== la0 || LabelOut_V_DO !== lv0 ||
          VoteCount_A_DO !== ca0 || VoteCount_V_DO !== cv0 || Fill_A_DO !== fa0 || Fill_V_DO !== fv0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b cntA=%0d fillA=%0d required 1 0 %0d %0d",
                 i, ValidOut_SO, ReadyOut_SO, VoteCount_A_DO, Fill_A_DO, ca0, fa0);
      end
    end
    ReadyIn_SI = 1'b1;
    @(posedge Clk_CI); @(negedge Clk_CI);
    ReadyIn_SI = 1'b0;
    checks++;
    if (ReadyOut_SO !== 1'b1 || ValidOut_SO !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", ReadyOut_SO, ValidOut_SO);
    end
    ValidIn_SI = 1'b0;
    send(1'b1, 30, 1'b0, 30, 1'b0);  // model confirms nothing was captured while stalled
    release_out();
  endtask

  task automatic test_flush_collision();
    for (int i = 0; i < 5; i++) begin send(1'b0, 100, 1'b1, 100, 1'b0); release_out(); end
    send(1'b1, 100, 1'b0, 100, 1'b1);
    checks++;
    if (Fill_A_DO !== 3'd1 || VoteCount_A_DO !== 3'd1 || LabelOut_A_DO !== 1'b1) begin
      errors++;
      $display("FAIL flush_collision: got fill=%0d cnt=%0d lab=%b required 1 1 1", Fill_A_DO, VoteCount_A_DO, LabelOut_A_DO);
    end
    release_out();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(998, 1002)) : int'($urandom_range(0, 2047));
      int dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(998, 1002)) : int'($urandom_range(0, 1300));
      send(1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 1)), dv, ($urandom_range(0, 7) == 0));
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tie_hold();
    test_threshold();
    test_backpressure();
    test_flush_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
